mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator/master side of the word-organised data memory port (clk, Reset, mem_access_addr, mem_write_data, mem_write_en, mem_read, mem_read_data).
- Accepts byte/half/word load and store requests from the CPU pipeline over a valid/ready handshake.
- Issues word-aligned memory cycles, doing read-modify-write for sub-word stores.
- Returns sign- or zero-extended load data with an error flag for misaligned or out-of-range accesses.

Parameters:
- MEM_BYTES, 4096, size of the addressable data memory in bytes; req_addr >= MEM_BYTES is an error.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, illegal size or out-of-range; no memory access was made.
- mem_access_addr  out  32  word-aligned address, bits[1:0] = 00.
- mem_write_data  out  32  full word to write.
- mem_write_en  out  1  write strobe; memory commits on the following negedge.
- mem_read  out  1  read enable; memory returns mem_read_data combinationally.
- mem_read_data  in  32  read word.

Behaviour:
- Clock/reset: one clock (clk); reset Reset is synchronous, active-high.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_access_addr=0, mem_write_data=0, mem_write_en=0, mem_read=0.
- Byte order is little-endian: byte offset k occupies word bits [8k+7:8k].
- States: IDLE, RD, RMW_RD, WR, RESP. mem_read is high only in RD and RMW_RD; mem_write_en is high only in WR. Both are decoded from registered state.
- IDLE, on req_valid at posedge: latch we, size, unsigned, addr, wdata; mem_access_addr <= {addr[31:2],2'b00}.
  - Error if size==11, or half with addr[0]=1, or word with addr[1:0]!=00, or addr>=MEM_BYTES. On error go to RESP with resp_err=1, rdata=0.
  - Otherwise: load -> RD; word store -> WR with mem_write_data=wdata; byte/half store -> RMW_RD.
- RD: next posedge captures mem_read_data, selects the byte/half by addr[1:0], extends per unsigned, loads resp_rdata -> RESP.
- RMW_RD: next posedge merges wdata[7:0] or wdata[15:0] into the read word at the addressed lane, loads mem_write_data -> WR.
- WR: one cycle; the write commits at the negedge inside this cycle; next posedge -> RESP with rdata=0, err=0.
- RESP: resp_valid=1, held stable until resp_ready is high at a posedge, then -> IDLE.
  - No new request is accepted in the same cycle; req_ready rises the cycle after the handshake.
- Latency from accept edge to resp_valid: error 1 cycle; load 2; SW 2; SB/SH 3. Maximum throughput is one request per latency+1 cycles.
- Addresses wrap inside the memory by word index addr[11:2] for MEM_BYTES=4096. The range check guarantees no aliasing.
- Reset mid-operation: Reset high at a posedge forces IDLE and clears all outputs at that edge. Any in-flight response is dropped.
  - A WR-state negedge already inside the cycle before that posedge still commits.
  - A half-done RMW never writes if Reset hits while in RMW_RD.
- req_valid while not IDLE is ignored; inputs are not sampled outside IDLE.
- resp_ready low holds RESP indefinitely with no memory activity.

Test Plan:
- Preload word 0x10 = 0x8899AABB; LB addr 0x12 signed -> resp_rdata 0xFFFFFF99, err 0, resp_valid 2 cycles after accept; LBU same addr -> 0x00000099.
- Preload 0x20 = 0x12345678; SH addr 0x22 wdata 0xFFFFCAFE -> one read cycle then one write cycle, memory word 0x20 = 0xCAFE5678, resp_valid 3 cycles after accept, rdata 0.
- SW addr 0x40 wdata 0xDEADBEEF, then LW 0x40 -> 0xDEADBEEF; LHU 0x42 -> 0x0000DEAD; LH 0x42 -> 0xFFFFDEAD.
- LW 0x41, SH 0x03, size 11, and LW 0x1000 -> each gives resp_err=1, rdata 0, 1-cycle latency, mem_read and mem_write_en never asserted.
- Hold resp_ready low 5 cycles after LW -> resp_valid and resp_rdata stable, req_ready 0, a pending req_valid is not accepted; it is accepted the cycle after resp_ready is sampled high.
- Assert Reset while in RMW_RD of SB 0x50 -> word 0x50 unchanged, all outputs at reset values next cycle, req_ready 1.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store access unit: turns byte/half/word CPU requests into word-aligned
// memory cycles, with read-modify-write for sub-word stores.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        Reset,
  // CPU request channel
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  // CPU response channel
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  // Word-organised data memory port
  output logic [31:0] mem_access_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_write_en,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_WR     = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [2:0]  state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req_err;
  logic [31:0] rd_shift;
  logic [31:0] load_ext;
  logic [31:0] merge_word;

  // Request legality: alignment by size, illegal size code, and range.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    req_err = 1'b0;
    case (req_size)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if (req_addr >= 32'(MEM_BYTES)) begin
      req_err = 1'b1;
    end
  end

  // Load path: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    rd_shift = mem_read_data >> {off_q, 3'b000};
    case (size_q)
      SZ_BYTE: load_ext = uns_q ? {24'd0, rd_shift[7:0]}
                                : {{24{rd_shift[7]}}, rd_shift[7:0]};
      SZ_HALF: load_ext = uns_q ? {16'd0, rd_shift[15:0]}
                                : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase
  end

  // Sub-word store path: overwrite only the addressed lane of the read word.
  always_comb begin
    merge_word = mem_read_data;
    if (size_q == SZ_HALF) begin
      if (off_q[1]) merge_word[31:16] = wdata_q;
      else          merge_word[15:0]  = wdata_q;
    end else begin
      case (off_q)
        2'd0:    merge_word[7:0]   = wdata_q[7:0];
        2'd1:    merge_word[15:8]  = wdata_q[7:0];
        2'd2:    merge_word[23:16] = wdata_q[7:0];
        default: merge_word[31:24] = wdata_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          size_d     = req_size;
          uns_d      = req_unsigned;
          off_d      = req_addr[1:0];
          wdata_d    = req_wdata[15:0];
          mem_addr_d = {req_addr[31:2], 2'b00};
          rdata_d    = 32'd0;
          err_d      = req_err;
          if (req_err) begin
            state_d = S_RESP;
          end else if (!req_we) begin
            state_d = S_RD;
          end else if (req_size == SZ_WORD) begin
            mem_wdata_d = req_wdata;
            state_d     = S_WR;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_RD: begin
        rdata_d = load_ext;
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        mem_wdata_d = merge_word;
        state_d     = S_WR;
      end
      S_WR: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (Reset) begin
      state_q     <= S_IDLE;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      off_q       <= 2'd0;
      wdata_q     <= 16'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Handshake and memory strobes are pure decodes of the registered state.
  assign req_ready       = (state_q == S_IDLE);
  assign resp_valid      = (state_q == S_RESP);
  assign mem_read        = (state_q == S_RD) || (state_q == S_RMW_RD);
  assign mem_write_en    = (state_q == S_WR);
  assign resp_rdata      = rdata_q;
  assign resp_err        = err_q;
  assign mem_access_addr = mem_addr_q;
  assign mem_write_data  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a behavioural byte-lane model predicts
// each response; an independent monitor checks responses, latency and memory cycles.
module tb_mem_access_unit;

  localparam int MEM_BYTES = 4096;
  localparam int NWORDS    = MEM_BYTES / 4;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_access_addr;
  logic [31:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk             (clk),
    .Reset           (Reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .mem_access_addr (mem_access_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read        (mem_read),
    .mem_read_data   (mem_read_data)
  );

  // Memory the DUT talks to, and the reference image the model maintains.
  logic [31:0] mem     [NWORDS];
  logic [31:0] ref_mem [NWORDS];

  assign mem_read_data = mem[mem_access_addr[11:2]];
  always @(negedge clk) if (mem_write_en) mem[mem_access_addr[11:2]] = mem_write_data;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    string       tag;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit rr_rand  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: byte-lane arithmetic on a word array.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
    int unsigned off, nbytes, widx;
    logic [31:0] mask, v;
    off     = addr % 4;
    e.rdata = 32'd0;
    e.tag   = "";
    e.err   = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
              (size == 2'd2 && off != 0) || (addr >= 32'(MEM_BYTES));
    if (e.err) begin
      e.lat = 1; e.nrd = 0; e.nwr = 0;
      return;
    end
    nbytes = 1 << size;
    mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    widx   = addr / 4;
    if (!we) begin
      v = (ref_mem[widx] >> (8 * off)) & mask;
      if (!uns && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
      e.rdata = v; e.lat = 2; e.nrd = 1; e.nwr = 0;
    end else begin
      ref_mem[widx] = (ref_mem[widx] & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
      e.lat = (nbytes == 4) ? 2 : 3;
      e.nrd = (nbytes == 4) ? 0 : 1;
      e.nwr = 1;
    end
  endtask

  // Monitor state
  int          rd_cnt = 0, wr_cnt = 0, rd_base = 0, wr_base = 0;
  int          acc_cyc = 0, hs_cyc = 0, first_cyc = 0;
  bit          seen = 1'b0;
  logic [31:0] hold_rdata = 32'd0;
  logic        hold_err = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!Reset) begin
      if (mem_read)     rd_cnt++;
      if (mem_write_en) wr_cnt++;
      if (req_valid && req_ready) begin
        acc_cyc = cyc + 1;
        rd_base = rd_cnt;
        wr_base = wr_cnt;
        seen    = 1'b0;
      end
      if (resp_valid) begin
        if (!seen) begin
          seen       = 1'b1;
          first_cyc  = cyc;
          hold_rdata = resp_rdata;
          hold_err   = resp_err;
        end else begin
          check("resp_rdata_stable", resp_rdata, hold_rdata);
          check("resp_err_stable", 32'(resp_err), 32'(hold_err));
        end
        check("req_ready_low_in_resp", 32'(req_ready), 32'd0);
        if (resp_ready) begin
          hs_cyc = cyc + 1;
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_resp: rdata 0x%08h err %0d with empty scoreboard", resp_rdata, resp_err);
          end else begin
            e = sb_q.pop_front();
            check({e.tag, ".rdata"}, resp_rdata, e.rdata);
            check({e.tag, ".err"}, 32'(resp_err), 32'(e.err));
            check({e.tag, ".latency"}, 32'(first_cyc - acc_cyc + 1), 32'(e.lat));
            check({e.tag, ".read_cycles"}, 32'(rd_cnt - rd_base), 32'(e.nrd));
            check({e.tag, ".write_cycles"}, 32'(wr_cnt - wr_base), 32'(e.nwr));
          end
        end
      end
    end
  end

  // Random back-pressure on the response channel
  initial forever begin
    @(posedge clk);
    #1;
    if (rr_rand) resp_ready = ($urandom_range(0, 3) != 0);
  end

  // Drive one request, wait for acceptance, then scramble the inputs.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input string tag,
                       input bit push, input bit use_exp, input logic [31:0] exp_rdata);
    exp_t e;
    bit   ok;
    int   budget;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    ok = 1'b0;
    budget = 0;
    while (!ok && budget < 200) begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk);
      budget++;
    end
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s.accept_timeout: req_ready never sampled high", tag);
      return;
    end
    if (push) begin
      model(we, size, uns, addr, wdata, e);
      if (use_exp) e.rdata = exp_rdata;
      e.tag = tag;
      sb_q.push_back(e);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_ready"},       32'(req_ready),    32'd1);
    check({tag, ".resp_valid"},      32'(resp_valid),   32'd0);
    check({tag, ".resp_err"},        32'(resp_err),     32'd0);
    check({tag, ".resp_rdata"},      resp_rdata,        32'd0);
    check({tag, ".mem_access_addr"}, mem_access_addr,   32'd0);
    check({tag, ".mem_write_data"},  mem_write_data,    32'd0);
    check({tag, ".mem_write_en"},    32'(mem_write_en), 32'd0);
    check({tag, ".mem_read"},        32'(mem_read),     32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_w;
    int          t, bad, first_bad, n_gap;
    logic [1:0]  sz;
    logic [31:0] a;
    int          r;

    for (int i = 0; i < NWORDS; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[32'h10 >> 2] = 32'h8899AABB; ref_mem[32'h10 >> 2] = 32'h8899AABB;
    mem[32'h20 >> 2] = 32'h12345678; ref_mem[32'h20 >> 2] = 32'h12345678;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    Reset = 1'b0;

    // Directed loads and stores
    issue(1'b0, 2'd0, 1'b0, 32'h12, 32'd0, "lb_12",  1, 1, 32'hFFFFFF99);
    issue(1'b0, 2'd0, 1'b1, 32'h12, 32'd0, "lbu_12", 1, 1, 32'h00000099);
    issue(1'b1, 2'd1, 1'b0, 32'h22, 32'hFFFFCAFE, "sh_22", 1, 1, 32'd0);
    drain();
    check("sh_22.mem_word_20", mem[32'h20 >> 2], 32'hCAFE5678);
    issue(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, "sw_40", 1, 1, 32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, "lw_40",  1, 1, 32'hDEADBEEF);
    issue(1'b0, 2'd1, 1'b1, 32'h42, 32'd0, "lhu_42", 1, 1, 32'h0000DEAD);
    issue(1'b0, 2'd1, 1'b0, 32'h42, 32'd0, "lh_42",  1, 1, 32'hFFFFDEAD);

    // Error cases
    issue(1'b0, 2'd2, 1'b0, 32'h41,   32'd0,        "err_lw_41",   1, 1, 32'd0);
    issue(1'b1, 2'd1, 1'b0, 32'h03,   32'h1234_5678, "err_sh_03",   1, 1, 32'd0);
    issue(1'b0, 2'd3, 1'b0, 32'h00,   32'd0,        "err_size11",  1, 1, 32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'd0,        "err_lw_1000", 1, 1, 32'd0);
    drain();

    // Response back-pressure with a pending request
    resp_ready = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, "lw_hold", 1, 1, 32'hDEADBEEF);
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'd0;
    req_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!resp_valid && t < 20);
    check("hold.resp_valid_arrived", 32'(resp_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("hold.req_ready", 32'(req_ready), 32'd0);
      check("hold.resp_valid", 32'(resp_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, "lw_pending", 1, 1, 32'h8899AABB);
    check("hold.pending_accept_cycle", 32'(acc_cyc), 32'(hs_cyc + 1));
    drain();

    // Reset while a sub-word store sits in its read phase
    old_w = mem[32'h50 >> 2];
    issue(1'b1, 2'd0, 1'b0, 32'h50, 32'h0000_00A5, "sb_50_reset", 0, 0, 32'd0);
    check("sb_50_reset.in_rmw_read", 32'(mem_read), 32'd1);
    Reset = 1'b1;
    @(posedge clk);
    #1;
    Reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    check("sb_50_reset.word_50_unchanged", mem[32'h50 >> 2], old_w);
    @(posedge clk);
    #1;

    // Randomized traffic with random back-pressure and idle gaps
    rr_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      r  = int'($urandom_range(0, 15));
      sz = (r == 0) ? 2'd3 : 2'(r % 3);
      r  = int'($urandom_range(0, 15));
      if (r == 0)      a = 32'(MEM_BYTES) + $urandom_range(0, 64);
      else if (r == 1) a = $urandom;
      else if (r == 2) a = 32'(MEM_BYTES) - 32'd1 - $urandom_range(0, 7);
      else             a = $urandom_range(0, 255);
      issue(1'($urandom), sz, 1'($urandom), a, $urandom, $sformatf("rnd%0d", n), 1, 0, 32'd0);
      n_gap = int'($urandom_range(0, 2));
      if (n_gap > 0) begin
        repeat (n_gap) @(posedge clk);
        #1;
      end
    end
    drain();

    // Final memory image against the model
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < NWORDS; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        if (first_bad < 0) first_bad = i;
        bad++;
      end
    end
    if (first_bad >= 0)
      $display("first differing word index %0d: mem 0x%08h model 0x%08h", first_bad, mem[first_bad], ref_mem[first_bad]);
    check("mem_image_mismatches", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
